// File: rtl/data_uncache_resp_pkg.sv
// Shared encodings for the uncached data responder: FSM states and access-size codes.
package data_uncache_resp_pkg;

    typedef enum logic [2:0] {
        UNC_IDLE    = 3'd0,
        UNC_RD_REQ  = 3'd1,
        UNC_RD_WAIT = 3'd2,
        UNC_WR_REQ  = 3'd3,
        UNC_RESP    = 3'd4
    } unc_state_t;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

endpackage

// File: rtl/data_uncache_resp.sv
// Uncached data responder: turns one execute-stage request into a single-beat bridge
// read or posted write, then returns a one-cycle data_ok toward the memory stage.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// UNC_IDLE    | ready; data_addr_ok high unless flush/reset
// UNC_RD_REQ  | rd_req held with latched type/address until rd_rdy
// UNC_RD_WAIT | capturing return beats until ret_last
// UNC_WR_REQ  | wr_req held with latched payload until wr_rdy
// UNC_RESP    | one-cycle data_ok (suppressed if the request was flushed)
module data_uncache_resp
    import data_uncache_resp_pkg::*;
#(
    parameter bit RD_FULL_WORD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_valid,
    input  logic        data_op,
    input  logic [2:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    input  logic [31:0] data_paddr,
    output logic        data_addr_ok,
    input  logic        flush,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data,
    output logic        wr_req,
    output logic [2:0]  wr_type,
    output logic [31:0] wr_addr,
    output logic [3:0]  wr_wstrb,
    output logic [31:0] wr_data,
    input  logic        wr_rdy
);

    unc_state_t  state;
    unc_state_t  state_nxt;
    logic        accept;
    logic        req_op;
    logic [2:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic [31:0] req_paddr;
    logic [2:0]  rd_type_q;
    logic [31:0] rd_addr_q;
    logic [31:0] ret_buf;
    logic        cancel;

    assign accept = data_valid && data_addr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= UNC_IDLE;
            req_op    <= 1'b0;
            req_size  <= 3'd0;
            req_wstrb <= 4'd0;
            req_wdata <= 32'd0;
            req_paddr <= 32'd0;
            rd_type_q <= 3'd0;
            rd_addr_q <= 32'd0;
            ret_buf   <= 32'd0;
            cancel    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_op    <= data_op;
                req_size  <= data_size;
                req_wstrb <= data_wstrb;
                req_wdata <= data_wdata;
                req_paddr <= data_paddr;
                // Full-word reads leave byte/half extraction to the memory stage.
                rd_type_q <= RD_FULL_WORD ? SIZE_WORD : data_size;
                rd_addr_q <= RD_FULL_WORD ? {data_paddr[31:2], 2'b00} : data_paddr;
            end
            if (state == UNC_RD_WAIT && ret_valid) begin
                ret_buf <= ret_data;
            end
            if (state == UNC_RESP) begin
                cancel <= 1'b0;
            end else if (flush && state != UNC_IDLE) begin
                cancel <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        data_addr_ok = 1'b0;
        rd_req       = 1'b0;
        wr_req       = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        case (state)
            UNC_IDLE: begin
                data_addr_ok = !flush && !reset;
                if (data_valid && !flush && !reset) begin
                    state_nxt = data_op ? UNC_WR_REQ : UNC_RD_REQ;
                end
            end
            UNC_RD_REQ: begin
                rd_req = 1'b1;
                if (rd_rdy) state_nxt = UNC_RD_WAIT;
            end
            UNC_RD_WAIT: begin
                if (ret_valid && ret_last) state_nxt = UNC_RESP;
            end
            UNC_WR_REQ: begin
                wr_req = 1'b1;
                if (wr_rdy) state_nxt = UNC_RESP;
            end
            UNC_RESP: begin
                // A flush arriving in this very cycle still kills the response.
                data_data_ok = !cancel && !flush;
                data_rdata   = req_op ? 32'd0 : ret_buf;
                state_nxt    = UNC_IDLE;
            end
            default: state_nxt = UNC_IDLE;
        endcase
    end

    assign rd_type  = rd_type_q;
    assign rd_addr  = rd_addr_q;
    assign wr_type  = req_size;
    assign wr_addr  = req_paddr;
    assign wr_wstrb = req_wstrb;
    assign wr_data  = req_wdata;

endmodule
